// File: rtl/sumador_16bits_pkg.sv
// -----------------------------------------------------------------------------
// sumador_16bits_pkg
//
// Shared definitions for the registered ripple-carry adder/subtractor.
//
// Contents:
//   SUMADOR_WIDTH : default operand/result width (16)
//   OP_ADD        : value of the control input that selects a + b
//   OP_SUB        : value of the control input that selects a - b
//   sumador_op_e  : enum view of the control encodings
// -----------------------------------------------------------------------------
package sumador_16bits_pkg;

  // Default datapath width for the adder/subtractor.
  localparam int SUMADOR_WIDTH = 16;

  // Operation select encodings carried on the 1-bit control input.
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic {
    SUMADOR_SUB = 1'b0,
    SUMADOR_ADD = 1'b1
  } sumador_op_e;

endpackage : sumador_16bits_pkg

// File: rtl/sumador_1bit.sv
// -----------------------------------------------------------------------------
// sumador_1bit
//
// One-bit full adder cell; WIDTH of these are chained by the top level to
// form the ripple-carry datapath.
//
// Ports:
//   a    (in)  operand bit A
//   b    (in)  operand bit B (already conditioned for add/subtract)
//   cin  (in)  carry in from the lower bit
//   sum  (out) sum bit
//   cout (out) carry out to the next bit
// -----------------------------------------------------------------------------
module sumador_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign sum     = a_xor_b ^ cin;
  // Carry is generated by a&b or propagated through a^b.
  assign cout    = (a & b) | (a_xor_b & cin);

endmodule : sumador_1bit

// File: rtl/sumador_16bits.sv
// -----------------------------------------------------------------------------
// sumador_16bits
//
// Registered unsigned adder/subtractor built from a ripple chain of
// sumador_1bit cells. One result per cycle, one cycle of latency, no
// handshake: a, b and control are sampled on every rising edge.
//
// Subtraction is two's complement: B is inverted and the chain carry-in is 1.
// The overflow flag is the chain carry-out on add and the inverted carry-out
// (a borrow, i.e. a < b) on subtract.
//
// Reset is asserted asynchronously (outputs clear immediately) and released
// through a two-flop synchronizer, so the output registers leave reset on a
// clean clock edge. The first edge after the synchronized release loads a
// valid result.
//
// Ports:
//   clk      (in)  clock, rising edge active
//   rst_n    (in)  asynchronous active-low reset
//   a        (in)  operand A, unsigned, WIDTH bits
//   b        (in)  operand B, unsigned, WIDTH bits
//   control  (in)  1 = add (a+b), 0 = subtract (a-b)
//   result   (out) registered low WIDTH bits of the selected operation
//   overflow (out) registered carry (add) / borrow (subtract)
// -----------------------------------------------------------------------------
module sumador_16bits
  import sumador_16bits_pkg::*;
#(
  parameter int WIDTH = SUMADOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             control,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assert asynchronously, release after two edges.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_sync;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_sync = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Operand conditioning: invert B and inject carry-in 1 for subtraction.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;

  assign b_eff    = (control == OP_ADD) ? b : ~b;
  assign carry_in = (control == OP_SUB);

  // ---------------------------------------------------------------------------
  // Ripple-carry chain. carry[0] is the chain input, carry[WIDTH] the output.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    sumador_1bit u_bit (
      .a   (a[i]),
      .b   (b_eff[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Output registers.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             overflow_d;
  logic             overflow_q;

  assign result_d = sum;
  // In subtract mode a carry-out of 1 means no borrow, so the flag is inverted.
  assign overflow_d = (control == OP_ADD) ? carry[WIDTH] : ~carry[WIDTH];

  // The raw rst_n is also in the clear term so the outputs drop immediately
  // on assertion, without waiting for the synchronizer to respond.
  logic out_rst_n;
  assign out_rst_n = rst_n & rst_n_sync;

  always_ff @(posedge clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule : sumador_16bits

// File: tb/tb_sumador_16bits.sv
// -----------------------------------------------------------------------------
// tb_sumador_16bits
//
// Directed bench for sumador_16bits: reset behaviour, add and subtract
// vectors with hand-computed results, back-to-back operands, control
// toggling with held operands, output hold between edges and a reset
// applied mid-stream.
// -----------------------------------------------------------------------------
module tb_sumador_16bits;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        control;
  logic [15:0] result;
  logic        overflow;

  int n_checks;
  int n_fail;

  sumador_16bits #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .control (control),
    .result  (result),
    .overflow(overflow)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver: present operands at the falling edge, then step to 1 time unit
  // after the next rising edge, where the registered outputs are sampled.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                       input logic cv);
    @(negedge clk);
    a       = av;
    b       = bv;
    control = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    a       = 16'h2222;
    b       = 16'h4444;
    control = 1'b1;
    #3;
    n_checks++;
    if (result !== 16'h0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%b expected 0000/0", result, overflow);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'h0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got %h/%b expected 0000/0", result, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Two synchronizer edges keep the outputs cleared.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (result !== 16'h0000 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sync_edge%0d: got %h/%b expected 0000/0",
                 i, result, overflow);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'h6666 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_load: got %h/%b expected 6666/0",
               result, overflow);
    end
  endtask

  task automatic test_add();
    logic [15:0] av [5] = '{16'h2222, 16'hFFFF, 16'h0001, 16'h8000, 16'h0000};
    logic [15:0] bv [5] = '{16'h4444, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0000};
    logic [15:0] er [5] = '{16'h6666, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0000};
    logic        eo [5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(av[i], bv[i], 1'b1);
      n_checks++;
      if (result !== er[i] || overflow !== eo[i]) begin
        n_fail++;
        $display("FAIL add[%0d] %h+%h: got %h/%b expected %h/%b",
                 i, av[i], bv[i], result, overflow, er[i], eo[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] av [6] = '{16'hFFFF, 16'h4444, 16'h2222, 16'h0000, 16'h0000, 16'h1234};
    logic [15:0] bv [6] = '{16'hFFFF, 16'h2222, 16'h4444, 16'h0000, 16'h0001, 16'h1234};
    logic [15:0] er [6] = '{16'h0000, 16'h2222, 16'hDDDE, 16'h0000, 16'hFFFF, 16'h0000};
    logic        eo [6] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(av[i], bv[i], 1'b0);
      n_checks++;
      if (result !== er[i] || overflow !== eo[i]) begin
        n_fail++;
        $display("FAIL sub[%0d] %h-%h: got %h/%b expected %h/%b",
                 i, av[i], bv[i], result, overflow, er[i], eo[i]);
      end
    end
  endtask

  // New operands every cycle, alternating operation.
  task automatic test_back_to_back();
    logic [15:0] av [4] = '{16'h00FF, 16'h0100, 16'hA5A5, 16'h8001};
    logic [15:0] bv [4] = '{16'h0001, 16'h0101, 16'h5A5A, 16'h8000};
    logic        cv [4] = '{1'b1,     1'b0,     1'b1,     1'b1};
    logic [15:0] er [4] = '{16'h0100, 16'hFFFF, 16'hFFFF, 16'h0001};
    logic        eo [4] = '{1'b0,     1'b1,     1'b0,     1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(av[i], bv[i], cv[i]);
      n_checks++;
      if (result !== er[i] || overflow !== eo[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h/%b expected %h/%b",
                 i, result, overflow, er[i], eo[i]);
      end
    end
  endtask

  task automatic test_control_toggle();
    drive(16'h1000, 16'h0010, 1'b1);
    n_checks++;
    if (result !== 16'h1010 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_add: got %h/%b expected 1010/0", result, overflow);
    end
    drive(16'h1000, 16'h0010, 1'b0);
    n_checks++;
    if (result !== 16'h0FF0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_sub: got %h/%b expected 0ff0/0", result, overflow);
    end
  endtask

  // Inputs change between edges; outputs must not follow until the next edge.
  task automatic test_hold();
    drive(16'h0003, 16'h0004, 1'b1);
    @(negedge clk);
    a       = 16'hFFFF;
    b       = 16'h0002;
    control = 1'b1;
    #1;
    n_checks++;
    if (result !== 16'h0007 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got %h/%b expected 0007/0", result, overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'h0001 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_next: got %h/%b expected 0001/1", result, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    n_checks++;
    if (result !== 16'hFFFE || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got %h/%b expected fffe/1", result, overflow);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (result !== 16'h0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_assert: got %h/%b expected 0000/0", result, overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'h0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_held: got %h/%b expected 0000/0", result, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'h0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sync: got %h/%b expected 0000/0", result, overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (result !== 16'hFFFE || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reload: got %h/%b expected fffe/1", result, overflow);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_control_toggle();
    test_hold();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_sumador_16bits

// File: doc/sumador_16bits.md
SUMADOR_16BITS -- requirements
Module: sumador_16bits

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; all requirements are stated for WIDTH=16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a  input  16  operand A, unsigned.
REQ-005 b  input  16  operand B, unsigned.
REQ-006 control  input  1  operation select: 1 = add (a+b), 0 = subtract (a-b).
REQ-007 result  output  16  registered result, low 16 bits of the selected operation.
REQ-008 overflow  output  1  registered unsigned overflow flag: carry-out on add, borrow on subtract.

Function
REQ-009 The adder datapath SHALL be a WIDTH-bit ripple-carry chain of 1-bit full adders.
REQ-010 Subtraction SHALL be two's-complement: B inverted bitwise, carry-in = 1.
REQ-011 Addition SHALL use B unmodified, carry-in = 0.
REQ-012 result SHALL equal (a + b) mod 2^16 when control=1, and (a - b) mod 2^16 when control=0.
REQ-013 overflow SHALL equal the final carry-out when control=1 (set iff a+b > 16'hFFFF).
REQ-014 overflow SHALL equal the inverted final carry-out when control=0 (set iff a < b).
REQ-015 a, b and control SHALL be sampled on the same rising edge that loads result and overflow.
REQ-016 Latency SHALL be exactly 1 cycle: inputs present before edge N appear on outputs after edge N.
REQ-017 The block SHALL accept new operands every cycle, with no handshake and no stall.
REQ-018 Outputs SHALL hold their value between edges, with no combinational path from inputs to outputs.
REQ-019 Changing control with a and b held SHALL take effect on the next edge.
REQ-020 Boundary: a=b, subtract, SHALL give result 0 with overflow 0.
REQ-021 Boundary: a=0, b=0, subtract, SHALL give result 0 with overflow 0.

Reset
REQ-022 While rst_n=0, result SHALL be 16'h0000 and overflow SHALL be 0, immediately and independent of clk.
REQ-023 Reset deassertion SHALL be synchronized to clk (two-flop release) before it affects the output registers.
REQ-024 After release, the first rising edge SHALL load a valid result.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight operation.

Structure
REQ-026 A shared package SHALL hold the WIDTH default (16) and the control encodings OP_ADD=1 and OP_SUB=0.
REQ-027 One sub-module, sumador_1bit (a, b, cin -> sum, cout), SHALL be instantiated WIDTH times by a generate loop.
REQ-028 The top level SHALL contain the B-inversion/carry-in logic, the adder chain, the output registers and the reset synchronizer only.

Verification
REQ-029 a=16'h2222, b=16'h4444, control=1 -> next cycle result=16'h6666, overflow=0.
REQ-030 a=16'hFFFF, b=16'hFFFF, control=1 -> result=16'hFFFE, overflow=1.
REQ-031 a=16'hFFFF, b=16'hFFFF, control=0 -> result=16'h0000, overflow=0.
REQ-032 a=16'h4444, b=16'h2222, control=0 -> result=16'h2222, overflow=0.
REQ-033 a=16'h2222, b=16'h4444, control=0 -> result=16'hDDDE, overflow=1.
REQ-034 Reset mid-stream: drive REQ-030 operands, then assert rst_n=0 between edges -> outputs drop to 16'h0000/0 at once; after release, the next edge reloads 16'hFFFE/1.
